freq_tick_gen: RTL and testbench
================================

// Module: freq_tick_gen
// PURPOSE
//  Upstream tick source for serial_out: drives its i_tick at one of two rates chosen per output bit.
//  Holds a DATA_BIT-wide frequency pattern; bit n selects HIGH (1) or LOW (0) divisor for data bit n.
//  Follows serial_out via its o_bit_tick/o_done_tick; shares i_start/i_stop/i_mode with it.
// PARAMETERS
//  DATA_BIT   32  bits per frame; must equal serial_out DATA_BIT
//  DIV_WIDTH  16  width of clock divisors / tick counter
// PORTS
//  clk             in   1          system clock
//  rst             in   1          synchronous, active-high reset
//  i_start         in   1          start pulse (same pulse as serial_out i_start)
//  i_stop          in   1          abort, any state
//  i_mode          in   1          0 = one-shot, 1 = repeat (sampled on i_done_tick)
//  i_freq_pattern  in   DATA_BIT   per-bit rate select, LSB = first bit; 1 = high div, 0 = low div
//  i_high_div      in   DIV_WIDTH  clk cycles per tick for pattern bit 1
//  i_low_div       in   DIV_WIDTH  clk cycles per tick for pattern bit 0
//  i_bit_tick      in   1          serial_out o_bit_tick: advance to next pattern bit
//  i_done_tick     in   1          serial_out o_done_tick: frame end
//  o_tick          out  1          one-clk tick pulse -> serial_out i_tick
//  o_busy          out  1          high when state != IDLE
//  o_sel           out  1          pattern bit in use (0 when not RUN)
//  o_cfg_err       out  1          one-clk pulse: start/reload rejected, a divisor was 0
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, counter/bit index/pattern/divisor latches 0.
//  All outputs registered. States: IDLE, RUN, WAIT_DONE.
//  IDLE: o_tick=0. i_start & both divs!=0 -> latch pattern+divs, cnt=0, bit_idx=0, -> RUN.
//   i_start with either div==0 -> o_cfg_err pulse next clk, stay IDLE.
//  RUN: div = pattern_buf[0] ? high_div_q : low_div_q. cnt 0..div-1, wraps to 0;
//   o_tick high the clk after cnt==div-1. First RUN clk = T1 -> first o_tick at T1+div, then every div clks.
//   div==1 -> o_tick every clk from T2. Divisors latched; input changes mid-frame have no effect.
//   i_bit_tick: pattern_buf >>= 1, cnt=0, no o_tick generated from this clk's count;
//   bit_idx++ ; if bit_idx==DATA_BIT-1 -> WAIT_DONE instead.
//  WAIT_DONE: o_tick=0. i_done_tick: i_mode=1 -> reload from inputs (same div check, err -> IDLE),
//   -> RUN with cnt=0, bit_idx=0; i_mode=0 -> IDLE.
//  i_stop in any state: -> IDLE next clk, o_tick 0 that clk; wins over i_start, i_bit_tick, i_done_tick.
//  i_bit_tick/i_done_tick outside their state: ignored. i_start outside IDLE: ignored.
//  rst mid-frame: reset values next clk, no o_tick emitted.
//  bit_idx width = $clog2(DATA_BIT); cnt width DIV_WIDTH, compare against div-1 without overflow.
// STRUCTURE
//  Package freq_tick_pkg: state encoding (IDLE/RUN/WAIT_DONE), MODE_ONE_SHOT=0, MODE_REPEAT=1,
//   SEL_LOW=0/SEL_HIGH=1.
//  Sub-module tick_divider: DIV_WIDTH counter, inputs en/clr/div, output registered terminal pulse;
//   top holds FSM, pattern shifter, bit index, divisor latches.
// TESTING (bench pairs this block with serial_out, TICK_PER_BIT=16)
//  1 high=2, low=5, pattern=32'h0000_0001, one-shot: bit0 ticks every 2 clks, bits1-31 every 5; 
//    total 16*2+31*16*5 tick-clks; o_busy falls 1 clk after done_tick.
//  2 high=1: o_tick continuous from T2 through bit0; o_sel=1 then 0 after first i_bit_tick.
//  3 repeat mode, pattern=32'hAAAA_AAAA: two frames back-to-back, second frame uses pattern
//    changed to 32'hFFFF_FFFF at done_tick; no o_tick during WAIT_DONE.
//  4 i_stop asserted on 100th clk of RUN: o_tick 0 from next clk, o_busy 0, o_sel 0.
//  5 i_start with low_div=0: o_cfg_err single pulse, o_busy stays 0, no o_tick.
//  6 rst pulsed mid-frame and i_start+i_stop same clk in IDLE: all outputs 0, stays IDLE.

Source files
------------

// File: rtl/freq_tick_gen_pkg.sv
// Shared encodings for the frequency-pattern tick generator: FSM states,
// repeat-mode and rate-select constants.
package freq_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  localparam logic MODE_ONE_SHOT = 1'b0;
  localparam logic MODE_REPEAT   = 1'b1;

  localparam logic SEL_LOW  = 1'b0;
  localparam logic SEL_HIGH = 1'b1;

endpackage

// File: rtl/freq_tick_gen_if.sv
// Control/status bundle between freq_tick_gen and its host side (serial_out
// handshake plus frame configuration).
interface freq_tick_gen_if #(
  parameter int DATA_BIT  = 32,
  parameter int DIV_WIDTH = 16
);
  logic                 i_start;
  logic                 i_stop;
  logic                 i_mode;
  logic [DATA_BIT-1:0]  i_freq_pattern;
  logic [DIV_WIDTH-1:0] i_high_div;
  logic [DIV_WIDTH-1:0] i_low_div;
  logic                 i_bit_tick;
  logic                 i_done_tick;
  logic                 o_tick;
  logic                 o_busy;
  logic                 o_sel;
  logic                 o_cfg_err;

  modport master (
    output i_start, i_stop, i_mode, i_freq_pattern, i_high_div, i_low_div,
           i_bit_tick, i_done_tick,
    input  o_tick, o_busy, o_sel, o_cfg_err
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_freq_pattern, i_high_div, i_low_div,
           i_bit_tick, i_done_tick,
    output o_tick, o_busy, o_sel, o_cfg_err
  );
endinterface

// File: rtl/freq_tick_gen_tick_divider.sv
// Programmable divider: counts 0..div-1 while enabled and emits a registered
// one-clock pulse the cycle after the terminal count.
module tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH:0]   cnt_inc;
  logic                 at_end;

  // One extra bit so cnt+1 == div cannot wrap for div == all-ones.
  assign cnt_inc = {1'b0, cnt} + {{DIV_WIDTH{1'b0}}, 1'b1};
  assign at_end  = (cnt_inc == {1'b0, div});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (at_end) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt_inc[DIV_WIDTH-1:0];
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_tick_gen.sv
// Tick source for serial_out: per data bit, picks the high or low divisor from
// a latched frequency pattern and advances on serial_out's bit/done ticks.
module freq_tick_gen
  import freq_tick_pkg::*;
#(
  parameter int DATA_BIT  = 32,
  parameter int DIV_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  freq_tick_gen_if.slave bus
);

  localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);

  state_e               state;
  logic [DATA_BIT-1:0]  pattern_buf;
  logic [DIV_WIDTH-1:0] high_div_q;
  logic [DIV_WIDTH-1:0] low_div_q;
  logic [DIV_WIDTH-1:0] cur_div;
  logic [IDX_W-1:0]     bit_idx;
  logic                 busy_q, sel_q, cfg_err_q, tick_q;
  logic                 divs_ok, start_req, load_ok, div_en, div_clr;

  assign divs_ok   = (bus.i_high_div != '0) && (bus.i_low_div != '0);
  // A fresh start in IDLE and a repeat reload at frame end share one load path.
  assign start_req = ((state == ST_IDLE) && bus.i_start) ||
                     ((state == ST_WAIT_DONE) && bus.i_done_tick && (bus.i_mode == MODE_REPEAT));
  assign load_ok   = start_req && divs_ok;

  assign cur_div = pattern_buf[0] ? high_div_q : low_div_q;
  assign div_en  = (state == ST_RUN) && !bus.i_stop;
  assign div_clr = (state == ST_RUN) && bus.i_bit_tick;

  tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .div  (cur_div),
    .tick (tick_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pattern_buf <= '0;
      high_div_q  <= '0;
      low_div_q   <= '0;
      bit_idx     <= '0;
      busy_q      <= 1'b0;
      sel_q       <= SEL_LOW;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (bus.i_stop) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        sel_q  <= SEL_LOW;
      end else if (load_ok) begin
        state       <= ST_RUN;
        pattern_buf <= bus.i_freq_pattern;
        high_div_q  <= bus.i_high_div;
        low_div_q   <= bus.i_low_div;
        bit_idx     <= '0;
        busy_q      <= 1'b1;
        sel_q       <= bus.i_freq_pattern[0];
      end else if (start_req) begin
        state     <= ST_IDLE;
        busy_q    <= 1'b0;
        sel_q     <= SEL_LOW;
        cfg_err_q <= 1'b1;
      end else begin
        unique case (state)
          ST_RUN: begin
            if (bus.i_bit_tick) begin
              pattern_buf <= pattern_buf >> 1;
              if (bit_idx == LAST_IDX) begin
                state <= ST_WAIT_DONE;
                sel_q <= SEL_LOW;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                sel_q   <= pattern_buf[1];
              end
            end
          end
          ST_WAIT_DONE: begin
            if (bus.i_done_tick) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
          ST_IDLE: ;
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            sel_q  <= SEL_LOW;
          end
        endcase
      end
    end
  end

  assign bus.o_tick    = tick_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_sel     = sel_q;
  assign bus.o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_freq_tick_gen.sv
// Scoreboard bench for freq_tick_gen with a behavioural serial_out partner
// (16 ticks per bit); tick and cfg_err timing are predicted per frame.
module tb_freq_tick_gen;
  import freq_tick_pkg::*;

  localparam int DATA_BIT     = 32;
  localparam int DIV_WIDTH    = 16;
  localparam int TICK_PER_BIT = 16;
  localparam int DONE_GAP     = 3;
  localparam int NO_LIMIT     = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_tick[$];
  int   exp_err[$];

  freq_tick_gen_if #(.DATA_BIT(DATA_BIT), .DIV_WIDTH(DIV_WIDTH)) bus ();

  freq_tick_gen #(.DATA_BIT(DATA_BIT), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predicts tick cycles of one frame; bit b starts at s and lasts 16*div+1 clks.
  function automatic int gen_frame(input int t1, input logic [31:0] pat,
                                   input int h, input int l, input int limit);
    int s;
    int d;
    s = t1;
    for (int b = 0; b < DATA_BIT; b++) begin
      d = pat[b] ? h : l;
      for (int k = 1; k <= TICK_PER_BIT; k++)
        if (s + k * d <= limit) exp_tick.push_back(s + k * d);
      s = s + TICK_PER_BIT * d + 1;
    end
    return s;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_frame(input logic [31:0] pat, input int h, input int l,
                             input logic mode, output int t1);
    bus.i_freq_pattern = pat;
    bus.i_high_div     = 16'(h);
    bus.i_low_div      = 16'(l);
    bus.i_mode         = mode;
    bus.i_start        = 1'b1;
    t1 = cyc + 1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Behavioural serial_out: counts o_tick, emits bit/done ticks.
  initial begin
    int tcnt, bcnt, dcnt;
    bit active, pend;
    tcnt = 0; bcnt = 0; dcnt = 0; active = 1'b0; pend = 1'b0;
    bus.i_bit_tick  = 1'b0;
    bus.i_done_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_bit_tick  = 1'b0;
      bus.i_done_tick = 1'b0;
      if (rst || bus.i_stop) begin
        active = 1'b0;
        pend   = 1'b0;
      end else if (!active) begin
        if (bus.i_start && bus.i_high_div != '0 && bus.i_low_div != '0) begin
          active = 1'b1; tcnt = 0; bcnt = 0; pend = 1'b0;
        end
      end else if (pend) begin
        dcnt++;
        if (dcnt == DONE_GAP) begin
          bus.i_done_tick = 1'b1;
          pend   = 1'b0;
          active = bus.i_mode;
          tcnt = 0; bcnt = 0;
        end
      end else if (bus.o_tick === 1'b1) begin
        tcnt++;
        if (tcnt == TICK_PER_BIT) begin
          tcnt = 0;
          bus.i_bit_tick = 1'b1;
          bcnt++;
          if (bcnt == DATA_BIT) begin
            bcnt = 0; pend = 1'b1; dcnt = 0;
          end
        end
      end
    end
  end

  // Monitor: every o_tick / o_cfg_err pulse must match the next predicted cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_tick === 1'b1) begin
        if (exp_tick.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tick_unexpected: o_tick=1 at cycle %0d, expected no tick", cyc);
        end else check("tick_cycle", cyc, exp_tick.pop_front());
      end
      if (bus.o_cfg_err === 1'b1) begin
        if (exp_err.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL cfg_err_unexpected: o_cfg_err=1 at cycle %0d, expected none", cyc);
        end else check("cfg_err_cycle", cyc, exp_err.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1, w, w2, c;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_mode = MODE_ONE_SHOT;
    bus.i_freq_pattern = '0; bus.i_high_div = '0; bus.i_low_div = '0;

    repeat (3) @(negedge clk);
    check("rst_tick",    32'(bus.o_tick),    0);
    check("rst_busy",    32'(bus.o_busy),    0);
    check("rst_sel",     32'(bus.o_sel),     0);
    check("rst_cfg_err", 32'(bus.o_cfg_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: bit0 high=2, rest low=5; mid-frame divisor changes must be ignored
    start_frame(32'h0000_0001, 2, 5, MODE_ONE_SHOT, t1);
    w = gen_frame(t1, 32'h0000_0001, 2, 5, NO_LIMIT);
    bus.i_high_div = 16'd7;
    bus.i_low_div  = 16'd9;
    check("t1_busy_run", 32'(bus.o_busy), 1);
    check("t1_sel_bit0", 32'(bus.o_sel),  1);
    wait_until(t1 + 40);
    check("t1_sel_bit1", 32'(bus.o_sel),  0);
    wait_until(w + DONE_GAP - 1);
    check("t1_busy_at_done", 32'(bus.o_busy), 1);
    wait_until(w + DONE_GAP);
    check("t1_busy_after_done", 32'(bus.o_busy), 0);
    check("t1_sel_idle",        32'(bus.o_sel),  0);
    check("t1_ticks_left",      exp_tick.size(), 0);
    repeat (2) @(negedge clk);

    // 2: high=1 gives continuous ticks through bit0
    start_frame(32'h0000_0001, 1, 3, MODE_ONE_SHOT, t1);
    w = gen_frame(t1, 32'h0000_0001, 1, 3, NO_LIMIT);
    check("t2_sel_first", 32'(bus.o_sel), 1);
    wait_until(t1 + 16);
    check("t2_sel_last_tick", 32'(bus.o_sel), 1);
    wait_until(t1 + 17);
    check("t2_sel_after_bit_tick", 32'(bus.o_sel), 0);
    wait_until(w + DONE_GAP);
    check("t2_busy_after_done", 32'(bus.o_busy), 0);
    check("t2_ticks_left",      exp_tick.size(), 0);
    repeat (2) @(negedge clk);

    // 3: repeat mode, pattern input changed mid-frame takes effect at reload
    start_frame(32'hAAAA_AAAA, 2, 3, MODE_REPEAT, t1);
    w  = gen_frame(t1, 32'hAAAA_AAAA, 2, 3, NO_LIMIT);
    w2 = gen_frame(w + DONE_GAP, 32'hFFFF_FFFF, 2, 3, NO_LIMIT);
    bus.i_freq_pattern = 32'hFFFF_FFFF;
    check("t3_sel_bit0_low", 32'(bus.o_sel), 0);
    wait_until(w + 1);
    check("t3_busy_wait_done", 32'(bus.o_busy), 1);
    check("t3_sel_wait_done",  32'(bus.o_sel),  0);
    wait_until(w + DONE_GAP);
    check("t3_busy_reload", 32'(bus.o_busy), 1);
    check("t3_sel_reload",  32'(bus.o_sel),  1);
    bus.i_mode = MODE_ONE_SHOT;
    wait_until(w2 + DONE_GAP);
    check("t3_busy_after_frame2", 32'(bus.o_busy), 0);
    check("t3_ticks_left",        exp_tick.size(), 0);
    repeat (2) @(negedge clk);

    // 4: stop on the 100th RUN clock while ticks are due every clock
    start_frame(32'h0000_0000, 7, 1, MODE_ONE_SHOT, t1);
    w = gen_frame(t1, 32'h0000_0000, 7, 1, t1 + 99);
    wait_until(t1 + 99);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    check("t4_tick_after_stop", 32'(bus.o_tick), 0);
    check("t4_busy_after_stop", 32'(bus.o_busy), 0);
    check("t4_sel_after_stop",  32'(bus.o_sel),  0);
    repeat (5) @(negedge clk);
    check("t4_busy_stays_idle", 32'(bus.o_busy), 0);
    check("t4_ticks_left",      exp_tick.size(), 0);

    // 5: zero divisor rejected with a single cfg_err pulse
    bus.i_high_div = 16'd4; bus.i_low_div = 16'd0; bus.i_start = 1'b1;
    c = cyc;
    exp_err.push_back(c + 1);
    @(negedge clk);
    bus.i_start = 1'b0;
    check("t5_cfg_err_pulse", 32'(bus.o_cfg_err), 1);
    check("t5_busy_low",      32'(bus.o_busy),    0);
    @(negedge clk);
    check("t5_cfg_err_single", 32'(bus.o_cfg_err), 0);
    bus.i_high_div = 16'd0; bus.i_low_div = 16'd4; bus.i_start = 1'b1;
    exp_err.push_back(cyc + 1);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_stays_idle", 32'(bus.o_busy), 0);
    check("t5_err_left",        exp_err.size(),  0);

    // 6: reset mid-frame, then start+stop together in IDLE
    start_frame(32'h0000_0001, 2, 5, MODE_ONE_SHOT, t1);
    w = gen_frame(t1, 32'h0000_0001, 2, 5, t1 + 50);
    wait_until(t1 + 50);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_tick",    32'(bus.o_tick),    0);
    check("t6_rst_busy",    32'(bus.o_busy),    0);
    check("t6_rst_sel",     32'(bus.o_sel),     0);
    check("t6_rst_cfg_err", 32'(bus.o_cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);
    bus.i_freq_pattern = 32'h0000_0001; bus.i_high_div = 16'd2; bus.i_low_div = 16'd5;
    bus.i_start = 1'b1; bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    check("t6_start_stop_busy", 32'(bus.o_busy), 0);
    check("t6_start_stop_sel",  32'(bus.o_sel),  0);
    repeat (10) @(negedge clk);
    check("t6_stays_idle", 32'(bus.o_busy), 0);
    check("t6_ticks_left", exp_tick.size(), 0);
    check("t6_err_left",   exp_err.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
